data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Multi-cycle data-memory responder for the ALU->DM pipeline stage; the producer of DMdone.
//  Serves loads with a fixed, parameterised latency; DMdone is the load-complete flag that
//  releases the pipeline stall. Serves stores as single-cycle posted writes, with no stall.
//  Holds the word-addressed data RAM.
// PARAMETERS
//  ADDR_W      8   word-address width; RAM depth = 2**ADDR_W 32-bit words
//  LD_LATENCY  2   BUSY cycles per load, >=1
// PORTS
//  clk       in   1   single clock; all state updates on posedge
//  reset     in   1   synchronous, active-high
//  is_Ld     in   1   load instruction present in DM stage
//  is_St     in   1   store instruction present in DM stage
//  stop      in   1   global pipeline freeze
//  address   in   32  byte-agnostic word address; RAM index = address[ADDR_W-1:0]
//  st_data   in   32  store data
//  ld_data   out  32  load result, registered, valid while DMdone=1
//  DMdone    out  1   load complete, registered
//  busy      out  1   1 when state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, DMdone=0, ld_data=0, busy=0, counter=0.
//    RAM contents are not cleared. Reset mid-load abandons the load; no RAM write occurs.
//  - FSM IDLE/BUSY/DONE.
//  - IDLE, is_Ld=1 (stop ignored):
//      latch addr_q=address[ADDR_W-1:0]; cnt<=LD_LATENCY-1; ->BUSY.
//  - IDLE, is_St=1 & is_Ld=0 & stop=0:
//      mem[address idx]<=st_data at that edge; stay IDLE; DMdone stays 0.
//  - IDLE, is_Ld=1 & is_St=1: load wins; store dropped (illegal encoding).
//  - IDLE, is_St=1 & stop=1: no write. The store is written once, on the first edge with stop=0.
//  - BUSY, cnt!=0: cnt--. BUSY, cnt==0: ld_data<=mem[addr_q]; DMdone<=1; ->DONE.
//      is_Ld, is_St and address are ignored in BUSY (pipeline is stalled).
//  - Latency: request sampled at end of cycle 0.
//      BUSY occupies cycles 1..LD_LATENCY; DMdone=1 in cycle LD_LATENCY+1.
//  - DONE, stop=0: DMdone<=0; ->IDLE.
//      DMdone is a 1-cycle pulse; that cycle the stall releases and the pipeline advances.
//  - DONE, stop=1: remain DONE; DMdone and ld_data held, so the frozen load is not re-issued.
//  - Back-to-back loads: the next load is sampled in the IDLE cycle after DONE.
//      Each load costs LD_LATENCY+2 cycles, including the IDLE sample cycle.
//  - Read-after-write: a store written at edge N is visible to a load whose BUSY read occurs after N.
//  - Address wrap: upper address bits [31:ADDR_W] ignored; index wraps modulo 2**ADDR_W.
//  - busy is registered-state derived: busy=1 exactly in BUSY and DONE.
// TESTING
//  1 Reset, then is_St=1, address=5, st_data=32'hDEADBEEF for 1 cycle
//      -> DMdone stays 0, busy stays 0.
//     Then is_Ld=1, address=5 -> DMdone=1 exactly in cycle 3, ld_data=32'hDEADBEEF, pulse 1 cycle.
//  2 Two consecutive loads, addr 1 then 2, with stored values 11/22.
//      -> DMdone pulses in cycles 3 and 7 with ld_data 11 then 22; busy low only in cycles 0 and 4.
//  3 Load addr 1 with stop=1 raised in DONE for 3 cycles
//      -> DMdone held high 4 cycles, ld_data stable, no second BUSY phase.
//  4 Store addr 3 with stop=1 for 2 cycles, then stop=0
//      -> RAM[3] written only after stop falls; a subsequent load returns the new value.
//  5 reset asserted during BUSY of a load
//      -> next cycle DMdone=0, busy=0, ld_data=0; a later load from the same addr returns the prior value.
//  6 address=32'h0000_0105 (ADDR_W=8) store 77, load address=5 -> ld_data=77 (wrap).
//     is_Ld=is_St=1 -> load performed, RAM unchanged.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the DM pipeline stage: fixed-latency loads that raise DMdone,
// posted single-cycle stores, and the word-addressed data RAM.
module data_mem_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int LD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_Ld,
  input  logic        is_St,
  input  logic        stop,
  input  logic [31:0] address,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        DMdone,
  output logic        busy
);

  localparam int CNT_W = (LD_LATENCY > 1) ? $clog2(LD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LD_LATENCY - 1);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         ld_data_q, ld_data_d;
  logic                done_q, done_d;
  logic                mem_we;
  logic [ADDR_W-1:0]   idx;
  logic [31:0]         mem [DEPTH];
  logic                unused_addr_hi;

  // Upper address bits are deliberately dropped so the index wraps modulo the RAM depth.
  assign idx            = address[ADDR_W-1:0];
  assign unused_addr_hi = ^address[31:ADDR_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    ld_data_d = ld_data_q;
    done_d    = done_q;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_Ld) begin
          addr_d  = idx;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end else if (is_St && !stop) begin
          mem_we = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ld_data_d = mem[addr_q];
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        // A frozen pipeline keeps the result parked here so the load is not re-issued.
        if (!stop) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      ld_data_q <= ld_data_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  // RAM contents survive reset; only the write itself is suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[idx] <= st_data;
    end
  end

  assign ld_data = ld_data_q;
  assign DMdone  = done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: stimulus queues the expected DMdone cycles and data,
// a negedge monitor pops and compares whenever DMdone is high.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        is_Ld = 1'b0;
  logic        is_St = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] st_data = '0;
  logic [31:0] ld_data;
  logic        DMdone;
  logic        busy;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] cyc = '0;
  int          tests = 0;
  int          fails = 0;

  data_mem_ctrl #(.ADDR_W(8), .LD_LATENCY(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .is_Ld   (is_Ld),
    .is_St   (is_St),
    .stop    (stop),
    .address (address),
    .st_data (st_data),
    .ld_data (ld_data),
    .DMdone  (DMdone),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every cycle with DMdone high must match the head of the scoreboard.
  always @(negedge clk) begin
    if (DMdone) begin
      exp_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL dmdone_unexpected: DMdone=1 at cycle %0d ld_data=%h, required DMdone=0", cyc, ld_data);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.data != ld_data) begin
          fails++;
          $display("FAIL dmdone_resp: got cycle %0d data %h, required cycle %0d data %h",
                   cyc, ld_data, e.cyc, e.data);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    is_St = 1'b1;
    address = a;
    st_data = d;
    step();
    is_St = 1'b0;
    check("store_dmdone", {31'b0, DMdone}, 32'd0);
    check("store_busy", {31'b0, busy}, 32'd0);
  endtask

  // Issues a load from IDLE; DMdone expected at t0+3 and held for `hold` extra stop cycles.
  task automatic do_load(input logic [31:0] a, input logic [31:0] exp_d, input int hold,
                         input logic also_st, input logic [31:0] sd);
    logic [31:0] t0;
    check("load_idle_busy", {31'b0, busy}, 32'd0);
    is_Ld = 1'b1;
    is_St = also_st;
    st_data = sd;
    address = a;
    t0 = cyc;
    for (int k = 0; k <= hold; k++) exp_q.push_back('{cyc: t0 + 32'd3 + k, data: exp_d});
    step();
    is_Ld = 1'b0;
    is_St = 1'b0;
    address = $urandom;
    check("load_busy_c1", {31'b0, busy}, 32'd1);
    step();
    check("load_busy_c2", {31'b0, busy}, 32'd1);
    step();
    check("load_busy_done", {31'b0, busy}, 32'd1);
    if (hold > 0) stop = 1'b1;
    repeat (hold) step();
    stop = 1'b0;
    step();
    check("load_after_busy", {31'b0, busy}, 32'd0);
    check("load_after_dmdone", {31'b0, DMdone}, 32'd0);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_dmdone", {31'b0, DMdone}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    reset = 1'b0;
    step();

    // 1: store then load, fixed latency
    do_store(32'd5, 32'hDEADBEEF);
    do_load(32'd5, 32'hDEADBEEF, 0, 1'b0, 32'd0);

    // 2: back-to-back loads
    do_store(32'd1, 32'd11);
    do_store(32'd2, 32'd22);
    do_load(32'd1, 32'd11, 0, 1'b0, 32'd0);
    do_load(32'd2, 32'd22, 0, 1'b0, 32'd0);

    // 3: stop held in DONE for three cycles
    do_load(32'd1, 32'd11, 3, 1'b0, 32'd0);

    // 4: store blocked while stop is high
    do_store(32'd3, 32'h33);
    is_St = 1'b1; stop = 1'b1; address = 32'd3; st_data = 32'h44;
    step(); step();
    is_St = 1'b0; stop = 1'b0;
    step();
    do_load(32'd3, 32'h33, 0, 1'b0, 32'd0);
    is_St = 1'b1; stop = 1'b1; address = 32'd3; st_data = 32'h55;
    step(); step();
    stop = 1'b0;
    step();
    is_St = 1'b0;
    do_load(32'd3, 32'h55, 0, 1'b0, 32'd0);

    // 5: reset during BUSY abandons the load
    is_Ld = 1'b1; address = 32'd1;
    step();
    is_Ld = 1'b0;
    check("rst5_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    step();
    check("rst5_dmdone", {31'b0, DMdone}, 32'd0);
    check("rst5_busy_after", {31'b0, busy}, 32'd0);
    check("rst5_ld_data", ld_data, 32'd0);
    reset = 1'b0;
    step();
    do_load(32'd1, 32'd11, 0, 1'b0, 32'd0);

    // 6: address wrap and simultaneous load/store
    do_store(32'h0000_0105, 32'd77);
    do_load(32'd5, 32'd77, 0, 1'b0, 32'd0);
    do_load(32'd5, 32'd77, 0, 1'b1, 32'd999);
    do_load(32'h0000_0F05, 32'd77, 0, 1'b0, 32'd0);

    repeat (3) step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_dmdone: got %0d responses outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
